// File: rtl/cam_frame_writer.sv
// Camera-side frame-buffer writer: turns the pixel strobe and v_sync/h_ref framing into
// registered RAM writes, ping-ponging between two banks so the display always reads a whole frame.
module cam_frame_writer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              pclk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [2:0]        data_in_i,
  input  logic              h_ref_i,
  input  logic              v_sync_i,
  output logic              mem_we_o,
  output logic [ADDR_W:0]   mem_addr_o,
  output logic [2:0]        mem_data_o,
  output logic              display_bank_o,
  output logic              frame_done_o,
  output logic              overflow_o,
  output logic              short_line_o
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0]     X_LIMIT   = XW'(H_ACTIVE);
  localparam logic [YW-1:0]     Y_LIMIT   = YW'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

  typedef enum logic [1:0] {IDLE, SYNC, CAPTURE} state_e;

  state_e              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [ADDR_W-1:0]   lineBase_q, lineBase_d;
  logic                bank_q, bank_d;
  logic                displayBank_q, displayBank_d;
  logic                memWe_q, memWe_d;
  logic [ADDR_W:0]     memAddr_q, memAddr_d;
  logic [2:0]          memData_q, memData_d;
  logic                frameDone_q, frameDone_d;
  logic                overflow_q, overflow_d;
  logic                shortLine_q, shortLine_d;
  logic                hRef_q, vSync_q;
  logic [XW-1:0]       xAfter;

  logic hFall, vRise, vFall, inWindow;
  assign hFall    = hRef_q & ~h_ref_i;
  assign vRise    = ~vSync_q & v_sync_i;
  assign vFall    = vSync_q & ~v_sync_i;
  assign inWindow = (x_q < X_LIMIT) && (y_q < Y_LIMIT);

  always_ff @(posedge pclk_i) begin
    hRef_q  <= h_ref_i;
    vSync_q <= v_sync_i;
    if (reset_i) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      lineBase_q    <= '0;
      bank_q        <= 1'b0;
      displayBank_q <= 1'b1;
      memWe_q       <= 1'b0;
      memAddr_q     <= '0;
      memData_q     <= '0;
      frameDone_q   <= 1'b0;
      overflow_q    <= 1'b0;
      shortLine_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      lineBase_q    <= lineBase_d;
      bank_q        <= bank_d;
      displayBank_q <= displayBank_d;
      memWe_q       <= memWe_d;
      memAddr_q     <= memAddr_d;
      memData_q     <= memData_d;
      frameDone_q   <= frameDone_d;
      overflow_q    <= overflow_d;
      shortLine_q   <= shortLine_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    lineBase_d    = lineBase_q;
    bank_d        = bank_q;
    displayBank_d = displayBank_q;
    memWe_d       = 1'b0;
    memAddr_d     = memAddr_q;
    memData_d     = memData_q;
    frameDone_d   = 1'b0;
    overflow_d    = overflow_q;
    shortLine_d   = shortLine_q;
    xAfter        = x_q;
    case (state_q)
      IDLE: begin
        if (vRise && enable_i) state_d = SYNC;
      end
      SYNC: begin
        x_d        = '0;
        y_d        = '0;
        lineBase_d = '0;
        if (vFall) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (write_i) begin
          if (inWindow) begin
            memWe_d   = 1'b1;
            memData_d = data_in_i;
            memAddr_d = {bank_q, lineBase_q + ADDR_W'(x_q)};
            xAfter    = x_q + XW'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
        x_d = xAfter;
        // Line advance sees the pixel count including a pixel accepted this same cycle.
        if (hFall && (xAfter != '0)) begin
          if ((xAfter < X_LIMIT) && (y_q < Y_LIMIT)) shortLine_d = 1'b1;
          if (y_q < Y_LIMIT) begin
            lineBase_d = lineBase_q + LINE_STEP;
            y_d        = y_q + YW'(1);
          end
          x_d = '0;
        end
        if (vRise) begin
          if ((y_q != '0) || (xAfter != '0)) begin
            frameDone_d   = 1'b1;
            displayBank_d = bank_q;
            bank_d        = ~bank_q;
          end
          state_d = enable_i ? SYNC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_we_o       = memWe_q;
  assign mem_addr_o     = memAddr_q;
  assign mem_data_o     = memData_q;
  assign display_bank_o = displayBank_q;
  assign frame_done_o   = frameDone_q;
  assign overflow_o     = overflow_q;
  assign short_line_o   = shortLine_q;

endmodule

// File: tb/tb_cam_frame_writer.sv
// Directed bench for cam_frame_writer with a 4x3 frame: addresses, latency, banking,
// reset recovery, overflow/short-line flags, enable gating and coincident-event ordering.
module tb_cam_frame_writer;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int AW = 4;

  logic          pclk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic          write = 1'b0;
  logic [2:0]    dataIn = 3'd0;
  logic          hRef = 1'b0;
  logic          vSync = 1'b0;
  logic          memWe;
  logic [AW:0]   memAddr;
  logic [2:0]    memData;
  logic          displayBank;
  logic          frameDone;
  logic          overflow;
  logic          shortLine;

  int assertCount = 0;
  int failCount   = 0;
  int cycleNo     = 0;
  int doneCount   = 0;
  int doneBase    = 0;
  int wrAddr[$];
  int wrData[$];
  int weCyc[$];
  int strobeCyc[$];

  cam_frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .pclk_i         (pclk),
    .reset_i        (reset),
    .enable_i       (enable),
    .write_i        (write),
    .data_in_i      (dataIn),
    .h_ref_i        (hRef),
    .v_sync_i       (vSync),
    .mem_we_o       (memWe),
    .mem_addr_o     (memAddr),
    .mem_data_o     (memData),
    .display_bank_o (displayBank),
    .frame_done_o   (frameDone),
    .overflow_o     (overflow),
    .short_line_o   (shortLine)
  );

  always #5 pclk = ~pclk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample #1 after the edge and log writes/pulses.
  task automatic applyStimulus(input logic wr, input logic [2:0] d, input logic href, input logic vs);
    write  = wr;
    dataIn = d;
    hRef   = href;
    vSync  = vs;
    @(posedge pclk);
    #1;
    cycleNo++;
    if (wr) strobeCyc.push_back(cycleNo);
    if (memWe === 1'b1) begin
      wrAddr.push_back(int'(memAddr));
      wrData.push_back(int'(memData));
      weCyc.push_back(cycleNo);
    end
    if (frameDone === 1'b1) doneCount++;
  endtask

  task automatic idleCycle(input logic vs);
    applyStimulus(1'b0, 3'd0, 1'b0, vs);
  endtask

  task automatic clearLog();
    wrAddr.delete();
    wrData.delete();
    weCyc.delete();
    strobeCyc.delete();
    doneBase = doneCount;
  endtask

  task automatic startFrame();
    idleCycle(1'b1);
    idleCycle(1'b1);
    idleCycle(1'b0);
    idleCycle(1'b0);
  endtask

  task automatic endFrame();
    idleCycle(1'b1);
    idleCycle(1'b0);
  endtask

  // n pixels on one h_ref line; optionally the last pixel shares its cycle with the h_ref fall.
  task automatic sendLine(input int n, input int firstData, input bit fallWithLast);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b1, 3'(firstData + i), (fallWithLast && (i == n - 1)) ? 1'b0 : 1'b1, 1'b0);
    if (!fallWithLast) idleCycle(1'b0);
    idleCycle(1'b0);
  endtask

  function automatic int logAddr(input int i);
    return (i < wrAddr.size()) ? wrAddr[i] : -1;
  endfunction

  function automatic int logData(input int i);
    return (i < wrData.size()) ? wrData[i] : -1;
  endfunction

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_we"},         32'(memWe),       0);
    checkOutput({pfx, "_addr"},       32'(memAddr),     0);
    checkOutput({pfx, "_data"},       32'(memData),     0);
    checkOutput({pfx, "_dispbank"},   32'(displayBank), 1);
    checkOutput({pfx, "_framedone"},  32'(frameDone),   0);
    checkOutput({pfx, "_overflow"},   32'(overflow),    0);
    checkOutput({pfx, "_shortline"},  32'(shortLine),   0);
  endtask

  initial begin
    int maxA;
    int expA[10];
    int expD[10];

    // Reset values, with a stray strobe present while reset is held.
    applyStimulus(1'b1, 3'd5, 1'b1, 1'b0);
    idleCycle(1'b0);
    checkResetValues("por");
    reset = 1'b0;
    idleCycle(1'b0);

    // Frame 1: 3 full lines into bank 0, one-cycle write latency.
    startFrame();
    clearLog();
    for (int l = 0; l < 3; l++) sendLine(4, 1, 1'b0);
    checkOutput("f1_count", wrAddr.size(), 12);
    for (int i = 0; i < 12; i++) begin
      checkOutput($sformatf("f1_addr%0d", i), logAddr(i), i);
      checkOutput($sformatf("f1_data%0d", i), logData(i), (i % 4) + 1);
      checkOutput($sformatf("f1_lat%0d", i), (i < weCyc.size()) ? weCyc[i] : -1,
                  (i < strobeCyc.size()) ? strobeCyc[i] : -2);
    end
    checkOutput("f1_we_low", 32'(memWe), 0);
    checkOutput("f1_addr_hold", 32'(memAddr), 11);
    checkOutput("f1_data_hold", 32'(memData), 4);
    idleCycle(1'b1);
    checkOutput("f1_done_pulse", 32'(frameDone), 1);
    checkOutput("f1_dispbank", 32'(displayBank), 0);
    idleCycle(1'b0);
    checkOutput("f1_done_low", 32'(frameDone), 0);
    checkOutput("f1_done_count", doneCount - doneBase, 1);

    // Frame 2 into bank 1, interrupted by reset mid-line after 2 pixels.
    startFrame();
    clearLog();
    sendLine(4, 5, 1'b0);
    applyStimulus(1'b1, 3'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'd2, 1'b1, 1'b0);
    checkOutput("f2_count", wrAddr.size(), 6);
    checkOutput("f2_first_addr", logAddr(0), 16);
    checkOutput("f2_last_addr", logAddr(5), 21);
    checkOutput("f2_data3", logData(3), 0);
    reset = 1'b1;
    applyStimulus(1'b1, 3'd3, 1'b1, 1'b0);
    checkResetValues("midrst");
    reset = 1'b0;

    // After reset: strobes ignored until a v_sync high-then-low sequence.
    clearLog();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'd2, 1'b1, 1'b1);
    applyStimulus(1'b1, 3'd2, 1'b1, 1'b1);
    checkOutput("rst_no_writes", wrAddr.size(), 0);
    idleCycle(1'b0);
    idleCycle(1'b0);

    // Frame 3: over-long first line plus a fourth line, all clipped to bank 0 addresses 0..11.
    sendLine(6, 1, 1'b0);
    for (int l = 0; l < 3; l++) sendLine(4, 1, 1'b0);
    checkOutput("f3_count", wrAddr.size(), 12);
    checkOutput("f3_first_addr", logAddr(0), 0);
    maxA = 0;
    foreach (wrAddr[i]) if (wrAddr[i] > maxA) maxA = wrAddr[i];
    checkOutput("f3_max_addr", maxA, 11);
    checkOutput("f3_addr4", logAddr(4), 4);
    checkOutput("f3_overflow", 32'(overflow), 1);
    checkOutput("f3_shortline", 32'(shortLine), 0);
    endFrame();
    checkOutput("f3_done_count", doneCount - doneBase, 1);
    checkOutput("f3_dispbank", 32'(displayBank), 0);

    // Frame 4 in bank 1: short line, pixel on the h_ref fall, pixel on the v_sync rise.
    startFrame();
    clearLog();
    sendLine(2, 1, 1'b0);
    checkOutput("f4_shortline", 32'(shortLine), 1);
    sendLine(4, 3, 1'b1);
    applyStimulus(1'b1, 3'd7, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'd2, 1'b1, 1'b1);
    checkOutput("f4_vrise_we", 32'(memWe), 1);
    checkOutput("f4_vrise_addr", 32'(memAddr), 27);
    checkOutput("f4_vrise_done", 32'(frameDone), 1);
    checkOutput("f4_dispbank", 32'(displayBank), 1);
    idleCycle(1'b0);
    expA = '{16, 17, 20, 21, 22, 23, 24, 25, 26, 27};
    expD = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
    checkOutput("f4_count", wrAddr.size(), 10);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("f4_addr%0d", i), logAddr(i), expA[i]);
      checkOutput($sformatf("f4_data%0d", i), logData(i), expD[i]);
    end
    checkOutput("f4_done_count", doneCount - doneBase, 1);

    // Frame 5 in bank 0; enable drops mid-frame, the frame still completes.
    startFrame();
    clearLog();
    sendLine(4, 1, 1'b0);
    enable = 1'b0;
    endFrame();
    checkOutput("f5_count", wrAddr.size(), 4);
    checkOutput("f5_first_addr", logAddr(0), 0);
    checkOutput("f5_done_count", doneCount - doneBase, 1);
    checkOutput("f5_dispbank", 32'(displayBank), 0);

    // Frame 6 with enable low: nothing written, no pulse.
    clearLog();
    startFrame();
    sendLine(4, 1, 1'b0);
    endFrame();
    checkOutput("f6_no_writes", wrAddr.size(), 0);
    checkOutput("f6_no_done", doneCount - doneBase, 0);

    // Frame 7 after re-enabling: resumes in bank 1.
    enable = 1'b1;
    clearLog();
    startFrame();
    sendLine(2, 4, 1'b0);
    endFrame();
    checkOutput("f7_count", wrAddr.size(), 2);
    checkOutput("f7_first_addr", logAddr(0), 16);
    checkOutput("f7_first_data", logData(0), 4);
    checkOutput("f7_done_count", doneCount - doneBase, 1);
    checkOutput("f7_dispbank", 32'(displayBank), 1);
    checkOutput("sticky_overflow", 32'(overflow), 1);
    checkOutput("sticky_shortline", 32'(shortLine), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
